// File: rtl/if_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
// Optional feature macro: IF_STATIC_BPRED_EN (static predict-taken for A64 unconditional B).
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'hD503201F;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam int unsigned PC_STEP  = 4;
  // Width of the stale-response drop counter; comfortably above any realistic in-flight count.
  localparam int unsigned DROP_W   = 8;

  typedef enum logic [1:0] {BOOT, FETCH, FULL} if_state_e;

endpackage

// File: rtl/if_slot_queue.sv
// In-order slot queue: entries {pc, inst, filled} with alloc (tail), fill and head pointers.
// With IF_STATIC_BPRED_EN defined it also supports a partial flush that keeps the head slots up to
// and including the slot being filled.
module if_slot_queue
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32,
  parameter int unsigned SLOTS  = 4,
  localparam int unsigned PTR_W = $clog2(SLOTS),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop,
  input  logic              flush_all,
`ifdef IF_STATIC_BPRED_EN
  input  logic              flush_keep,
  output logic [ADDR_W-1:0] fill_pc,
`endif
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  unfilled
);

  logic [ADDR_W-1:0] pc_q   [SLOTS];
  logic [INST_W-1:0] inst_q [SLOTS];
  logic [SLOTS-1:0]  filled_q;
  logic [PTR_W-1:0]  head_q, fill_q, tail_q;
  logic [CNT_W-1:0]  count_q, unfilled_q;

  assign head_valid = filled_q[head_q];
  assign head_pc    = pc_q[head_q];
  assign head_inst  = inst_q[head_q];
  assign count      = count_q;
  assign unfilled   = unfilled_q;

`ifdef IF_STATIC_BPRED_EN
  logic [CNT_W-1:0] keep_cnt;
  assign fill_pc  = pc_q[fill_q];
  // Slots surviving a predicted branch: head through the branch slot, minus a same-cycle pop.
  assign keep_cnt = CNT_W'(PTR_W'(fill_q - head_q)) + CNT_W'(1) - CNT_W'(pop);
`endif

  // Slot storage and pointer/occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      filled_q   <= '0;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else if (flush_all) begin
      filled_q   <= '0;
      fill_q     <= head_q;
      tail_q     <= head_q;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      if (fill) begin
        inst_q[fill_q]   <= fill_inst;
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + 1'b1;
      end
      if (alloc) begin
        pc_q[tail_q]     <= alloc_pc;
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + 1'b1;
      end
      count_q    <= count_q + CNT_W'(alloc) - CNT_W'(pop);
      unfilled_q <= unfilled_q + CNT_W'(alloc) - CNT_W'(fill);
`ifdef IF_STATIC_BPRED_EN
      // Younger slots are all unfilled, so dropping them just rewinds the tail.
      if (flush_keep) begin
        tail_q     <= fill_q + 1'b1;
        count_q    <= keep_cnt;
        unfilled_q <= '0;
      end
`endif
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues pipelined imem requests, buffers responses in an
// in-order slot queue and hands {pc, inst} to ID. Redirects discard stale in-flight responses.
// Optional feature macro: IF_STATIC_BPRED_EN (predict-taken redirect on unconditional B).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       SLOTS    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  localparam int unsigned CNT_W = $clog2(SLOTS) + 1;

  if_state_e         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DROP_W-1:0] drop_q;
  logic [DROP_W-1:0] outstanding;
  logic [CNT_W-1:0]  count, unfilled;
  logic              head_valid, rv_drop, rv_fill, fill, req, issue, pop, predict;

  assign outstanding = drop_q + DROP_W'(unfilled);
  // Stale responses always sit ahead of live ones, so they are consumed first.
  assign rv_drop     = imem_rvalid_i && (drop_q != '0);
  assign rv_fill     = imem_rvalid_i && (drop_q == '0) && (unfilled != '0);
  assign fill        = rv_fill && !redirect_i;

`ifdef IF_STATIC_BPRED_EN
  logic [ADDR_W-1:0] fill_pc, target;
  assign predict = rv_fill && !redirect_i && (imem_rdata_i[31:26] == OPC_B);
  assign target  = fill_pc + {{(ADDR_W-28){imem_rdata_i[25]}}, imem_rdata_i[25:0], 2'b00};
`else
  assign predict = 1'b0;
`endif

  assign req   = (state_q == FETCH) && !redirect_i && !predict && (count < CNT_W'(SLOTS));
  assign issue = req && imem_gnt_i;
  assign pop   = head_valid && id_ready_i && !redirect_i;

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign id_valid_o  = head_valid;

  if_slot_queue #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W),
    .SLOTS (SLOTS)
  ) u_slot_queue (
    .clock     (clock),
    .reset     (reset),
    .alloc     (issue),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_inst (imem_rdata_i),
    .pop       (pop),
    .flush_all (redirect_i),
`ifdef IF_STATIC_BPRED_EN
    .flush_keep(predict),
    .fill_pc   (fill_pc),
`endif
    .head_valid(head_valid),
    .head_pc   (id_pc_o),
    .head_inst (id_inst_o),
    .count     (count),
    .unfilled  (unfilled)
  );

  // PC, fetch FSM and stale-response drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else if (redirect_i) begin
      state_q <= FETCH;
      pc_q    <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
      // A response arriving right now is itself stale and already accounted for.
      drop_q  <= outstanding - DROP_W'(imem_rvalid_i && (outstanding != '0));
`ifdef IF_STATIC_BPRED_EN
    end else if (predict) begin
      state_q <= FETCH;
      pc_q    <= target;
      // drop_q is zero on any fill; the branch slot itself is being filled.
      drop_q  <= DROP_W'(unfilled) - DROP_W'(1);
`endif
    end else begin
      if (issue) pc_q <= pc_q + ADDR_W'(PC_STEP);
      if (rv_drop) drop_q <= drop_q - DROP_W'(1);
      case (state_q)
        BOOT:    state_q <= FETCH;
        FETCH:   if (issue && ((count + CNT_W'(1) - CNT_W'(pop)) == CNT_W'(SLOTS))) state_q <= FULL;
        FULL:    if (pop) state_q <= FETCH;
        default: state_q <= BOOT;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Memory must never return data that was not requested.
  rvalid_has_req: assert property (@(posedge clock) disable iff (!reset)
                                   imem_rvalid_i |-> (outstanding != '0))
    else $error("if_fetch_unit: rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed reset/backpressure sequences, a table of
// redirect vectors and a randomized phase checked against a program-order PC model.
module tb_if_fetch_unit;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned SLOTS  = 4;
`ifdef IF_STATIC_BPRED_EN
  localparam bit BPRED = 1'b1;
`else
  localparam bit BPRED = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i, id_valid_o, id_ready_i;
  logic [ADDR_W-1:0] imem_addr_o, redirect_pc_i, id_pc_o;
  logic [INST_W-1:0] imem_rdata_i, id_inst_o;

  if_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .SLOTS   (SLOTS),
    .RESET_PC(64'h0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] tgt;
    int          lat;
    bit          b2b;
    bit          chk_same;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc, last_due, first_valid, n_issue, gnt_pct, ready_pct, lat_min, lat_max;
  bit          saw_rvalid, saw_valid;
  logic [63:0] exp_pc;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] pop_log[$];

  // Instruction memory contents; 0x40 holds B -8, everything else is a non-branch.
  function automatic logic [31:0] mem_inst(input logic [63:0] a);
    if (a == 64'h40) return 32'h17FF_FFFE;
    return {6'b110100, a[27:2] ^ a[53:28]};
  endfunction

  // Program-order successor of an instruction delivered to ID.
  function automatic logic [63:0] next_pc(input logic [63:0] pc, input logic [31:0] inst);
    if (BPRED && inst[31:26] == 6'b000101) return pc + {{36{inst[25]}}, inst[25:0], 2'b00};
    return pc + 64'd4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, sample at mid-cycle, update model, advance past the edge.
  task automatic tick(input bit redir, input logic [63:0] tgt);
    int lat;
    redirect_i    = redir;
    redirect_pc_i = redir ? tgt : {$urandom, $urandom};
    imem_gnt_i    = (int'($urandom_range(0, 99)) < gnt_pct);
    id_ready_i    = (int'($urandom_range(0, 99)) < ready_pct);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_inst(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #2;
    saw_rvalid = imem_rvalid_i;
    saw_valid  = id_valid_o;
    if (id_valid_o && first_valid < 0) first_valid = cyc;
    if (redir) chk("req_during_redirect", imem_req_o, 64'd0);
    if (id_valid_o && id_ready_i && !redir) begin
      chk("id_pc", id_pc_o, exp_pc);
      chk("id_inst", id_inst_o, mem_inst(exp_pc));
      pop_log.push_back(id_pc_o);
      exp_pc = next_pc(exp_pc, mem_inst(exp_pc));
    end
    if (redir) exp_pc = tgt & ~64'h3;
    if (imem_req_o && imem_gnt_i) begin
      chk("addr_align", imem_addr_o[1:0], 64'd0);
      lat      = int'($urandom_range(lat_min, lat_max));
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      pend_addr.push_back(imem_addr_o);
      pend_due.push_back(last_due);
      n_issue++;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    id_ready_i    = 1'b0;
    #1;
    chk("rst_req", imem_req_o, 64'd0);
    chk("rst_addr", imem_addr_o, 64'd0);
    chk("rst_valid", id_valid_o, 64'd0);
    chk("rst_pc", id_pc_o, 64'd0);
    chk("rst_inst", id_inst_o, 64'd0);
    pend_addr.delete();
    pend_due.delete();
    pop_log.delete();
    last_due    = 0;
    exp_pc      = 64'h0;
    first_valid = -1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = 0;
    #1;
    chk("boot_no_req", imem_req_o, 64'd0);
  endtask

  vec_t        vecs[6];
  int          sel, pops_before;
  bit          rd;
  logic [63:0] t;

  initial begin
    redirect_pc_i = '0;
    imem_rdata_i  = '0;
    cyc           = 0;
    n_issue       = 0;
    vecs[0] = '{64'h1002, 3, 1'b0, 1'b0, 64'h1000, 64'h1004};
    vecs[1] = '{64'h3000, 1, 1'b0, 1'b1, 64'h3000, 64'h3004};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 2, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[3] = '{64'h40, 1, 1'b0, 1'b0, 64'h40, BPRED ? 64'h38 : 64'h44};
    vecs[4] = '{64'h7, 4, 1'b0, 1'b0, 64'h4, 64'h8};
    vecs[5] = '{64'h6000, 4, 1'b1, 1'b0, 64'h6000, 64'h6004};

    // Reset release, ideal memory: one instruction per cycle from 0.
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    repeat (12) tick(1'b0, 64'h0);
    chk("first_valid_cycle", 64'(first_valid), 64'd3);
    chk("pops_one_per_cycle", 64'(pop_log.size()), 64'd9);
    if (pop_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("seq_pc", pop_log[i], 64'(i * 4));

    // Backpressure: queue fills to SLOTS, request drops, resumes after one pop.
    tick(1'b1, 64'h2000);
    ready_pct = 0;
    n_issue   = 0;
    repeat (10) tick(1'b0, 64'h0);
    chk("full_issue_count", 64'(n_issue), 64'(SLOTS));
    chk("full_req_low", imem_req_o, 64'd0);
    chk("stall_hold_pc", id_pc_o, 64'h2000);
    ready_pct = 100;
    pop_log.delete();
    tick(1'b0, 64'h0);
    chk("full_one_pop", 64'(pop_log.size()), 64'd1);
    chk("req_resumes", imem_req_o, 64'd1);
    repeat (10) tick(1'b0, 64'h0);

    // Redirect vectors: first two PCs reaching ID after the redirect.
    for (int v = 0; v < 6; v++) begin
      gnt_pct = 100; ready_pct = 100; lat_min = vecs[v].lat; lat_max = vecs[v].lat;
      repeat (8) tick(1'b0, 64'h0);
      if (vecs[v].b2b) tick(1'b1, vecs[v].tgt ^ 64'h100);
      tick(1'b1, vecs[v].tgt);
      if (vecs[v].chk_same) begin
        chk("redirect_rvalid_same_cycle", 64'(saw_rvalid), 64'd1);
        chk("redirect_valid_same_cycle", 64'(saw_valid), 64'd1);
      end
      pop_log.delete();
      for (int k = 0; k < 60 && pop_log.size() < 2; k++) tick(1'b0, 64'h0);
      if (pop_log.size() < 2) begin
        checks++;
        errors++;
        $display("FAIL vec%0d_timeout: got %0d pops required 2", v, pop_log.size());
      end else begin
        chk($sformatf("vec%0d_pc0", v), pop_log[0], vecs[v].exp0);
        chk($sformatf("vec%0d_pc1", v), pop_log[1], vecs[v].exp1);
      end
    end

    // Randomized traffic with occasional redirects.
    pop_log.delete();
    for (int r = 0; r < 40; r++) begin
      gnt_pct   = int'($urandom_range(30, 100));
      ready_pct = int'($urandom_range(30, 100));
      lat_min   = 1;
      lat_max   = int'($urandom_range(1, 5));
      repeat (60) begin
        rd  = ($urandom_range(0, 19) == 0);
        sel = int'($urandom_range(0, 2));
        if (sel == 0) t = {$urandom, $urandom};
        else if (sel == 1) t = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
        else t = 64'h20 + 64'($urandom_range(0, 63));
        tick(rd, t);
      end
    end
    chk("random_progress", 64'(pop_log.size() > 100), 64'd1);

    // Reset with requests in flight, then restart from RESET_PC.
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 2; lat_max = 2;
    repeat (10) tick(1'b0, 64'h0);
    pops_before = pop_log.size();
    chk("post_reset_pops", 64'(pops_before >= 4), 64'd1);
    if (pops_before > 0) chk("post_reset_first_pc", pop_log[0], 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
